register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
// - Parametrised multi-read-port integer register file with write-to-read bypass, optional registered reads and
//   a per-register pending-write scoreboard. Replaces the fixed 2R/1W file in the pipelined core's decode stage.
// - Decode reads operands and marks the issuing instruction's rd busy; writeback writes and clears busy.
// - x0 is hardwired to zero; x2 (sp) resets to SP_INIT.
// PARAMETERS
// - DWIDTH     32          data width
// - NUM_REGS   32          architectural registers; 32 (RV32I) or 16 (RV32E); AW = $clog2(NUM_REGS)
// - NRD        2           read ports, 1..4
// - BYPASS     1           1: same-cycle writeback data forwarded to read ports; 0: read returns stored value
// - SYNC_READ  0           0: combinational read; 1: read data and busy registered, 1-cycle latency
// - SP_INIT    32'h01000000 reset value of x2 (must match the stack-top constant in constants.svh)
// PORTS
// - clk         in   1            clock; all state updates on posedge clk
// - rst         in   1            synchronous, active-high reset
// - rs_i        in   NRD x AW     read addresses, one per port
// - rsdata_o    out  NRD x DWIDTH read data
// - rsbusy_o    out  NRD          1 = addressed register has an outstanding write (consumer must stall)
// - rd_i        in   AW           writeback destination
// - datawb_i    in   DWIDTH       writeback data
// - regwren_i   in   1            writeback enable
// - mark_i      in   1            issue: set busy on mark_rd_i
// - mark_rd_i   in   AW           issuing instruction's destination
// - busy_vec_o  out  NUM_REGS     full scoreboard, for debug/hazard unit
// BEHAVIOUR
// - Reset (rst=1 at posedge): all regs <= 0 except x2 <= SP_INIT; busy bits <= 0; registered outputs <= 0.
//   Writes and marks in a reset cycle are dropped. Reset mid-stream discards all pending busy bits.
// - Write: posedge with regwren_i=1 and rd_i!=0 -> regs[rd_i] <= datawb_i. rd_i==0 ignored, x0 always reads 0.
// - Read (SYNC_READ=0): rsdata_o[p] = 0 if rs_i[p]==0; else datawb_i if BYPASS && regwren_i && rd_i==rs_i[p];
//   else regs[rs_i[p]]. rsbusy_o[p] = busy[rs_i[p]] && !(BYPASS && regwren_i && rd_i==rs_i[p]); x0 never busy.
// - Read (SYNC_READ=1): same function sampled at posedge, presented next cycle (latency 1); bypass compares
//   against the writeback in the sampling cycle.
// - Scoreboard per reg r!=0: set if mark_i && mark_rd_i==r; clear if regwren_i && rd_i==r; both same cycle ->
//   stays set (newer producer wins). mark_rd_i==0 ignored. Marking an already-busy reg keeps it busy (single
//   bit, no count; the pipeline guarantees in-order writeback, so the first writeback clears it).
// - Writeback to a non-busy reg is legal (writes data, busy stays 0).
// - Addresses >= NUM_REGS (non-power-of-2 never occurs; for RV32E AW=4) need no handling.
// - NRD ports fully independent; duplicate addresses on several ports return identical data/busy.
// STRUCTURE
// - rf_pkg: typedef logic [AW-1:0] reg_addr_t, localparam SP_IDX=2, ZERO_IDX=0; DWIDTH-generic data typedef.
// - Sub-module reg_scoreboard (NUM_REGS busy bits, set/clear priority, x0 mask) instantiated once.
// - Generate loop over NRD for read/bypass mux; generate-if on SYNC_READ for output registers.
// TESTING
// - Reset: rst 1 cycle -> read x2 = 32'h01000000, x1..x31 (except x2) = 0, busy_vec_o = 0.
// - Write/read: wr x5=32'hDEADBEEF, next cycle rs_i[0]=5 -> 32'hDEADBEEF; wr x0=32'h1234 -> x0 reads 0.
// - Bypass: same cycle wr x7=32'hA5A5A5A5, rs_i[1]=7 -> BYPASS=1 returns A5A5A5A5, busy 0; BYPASS=0 old value.
// - Scoreboard: mark x3; next cycle rsbusy for x3 = 1; wr x3=9 -> busy clears, reads 9; mark+wr x3 same cycle
//   -> busy stays 1.
// - SYNC_READ=1: rs_i[0]=5 at cycle n -> rsdata_o[0] valid at n+1; rst mid-stream with x4 busy -> busy_vec_o=0.
// - Config sweep NUM_REGS=16, NRD=3: all three ports read distinct regs correctly; random writes vs model.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file slice.
// Holds architectural register indices and reset defaults used by
// register_file_mp and reg_scoreboard. Width-dependent typedefs live in the
// modules, because they follow each instance's parameters.
package rf_pkg;

  localparam int unsigned ZERO_IDX = 0;  // x0: hardwired zero
  localparam int unsigned SP_IDX   = 2;  // x2: stack pointer

  localparam int unsigned DWIDTH_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam logic [31:0] SP_INIT_DEF  = 32'h0100_0000;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all bits)
//   set_i/set_idx_i   issue marks set_idx_i busy
//   clr_i/clr_idx_i   writeback clears clr_idx_i
//   busy_o            busy vector, bit 0 (x0) is never set
// A set and a clear of the same register in one cycle leave it set: the
// newer producer still has to write back.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [AW-1:0]       set_idx_i,
  input  logic                clr_i,
  input  logic [AW-1:0]       clr_idx_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_i) set_vec[set_idx_i] = 1'b1;
    if (clr_i) clr_vec[clr_idx_i] = 1'b1;
    set_vec[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_o <= '0;
    else     busy_o <= (busy_o & ~clr_vec) | set_vec;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with writeback bypass, optional
// registered reads and a pending-write scoreboard.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rs_i         NRD read addresses
//   rsdata_o     NRD read data (x0 reads 0)
//   rsbusy_o     NRD busy flags: addressed register awaits a writeback
//   rd_i, datawb_i, regwren_i   writeback port (writes to x0 ignored)
//   mark_i, mark_rd_i           issue-time busy marking
//   busy_vec_o   full scoreboard vector
// x2 resets to SP_INIT, all other registers to 0.
module register_file_mp
  import rf_pkg::*;
#(
  parameter  int unsigned         DWIDTH    = DWIDTH_DEF,
  parameter  int unsigned         NUM_REGS  = NUM_REGS_DEF,
  parameter  int unsigned         NRD       = 2,
  parameter  int unsigned         BYPASS    = 1,
  parameter  int unsigned         SYNC_READ = 0,
  parameter  logic [DWIDTH-1:0]   SP_INIT   = DWIDTH'(SP_INIT_DEF),
  localparam int unsigned         AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD-1:0][AW-1:0]       rs_i,
  output logic [NRD-1:0][DWIDTH-1:0]   rsdata_o,
  output logic [NRD-1:0]               rsbusy_o,
  input  logic [AW-1:0]                rd_i,
  input  logic [DWIDTH-1:0]            datawb_i,
  input  logic                         regwren_i,
  input  logic                         mark_i,
  input  logic [AW-1:0]                mark_rd_i,
  output logic [NUM_REGS-1:0]          busy_vec_o
);

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [DWIDTH-1:0] reg_data_t;

  reg_data_t regs [NUM_REGS];

  // Storage: one register per generate block so each element has a single
  // driver; x0 is a constant.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_IDX) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_store
      reg_data_t q;
      always_ff @(posedge clk) begin
        if (rst)
          q <= (g == SP_IDX) ? SP_INIT : '0;
        else if (regwren_i && (rd_i == reg_addr_t'(g)))
          q <= datawb_i;
      end
      assign regs[g] = q;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_i     (mark_i),
    .set_idx_i (mark_rd_i),
    .clr_i     (regwren_i),
    .clr_idx_i (rd_i),
    .busy_o    (busy_vec_o)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic      wb_hit;
    reg_data_t rd_val;
    logic      rd_busy;

    // A writeback to the addressed register this cycle both supplies the
    // data and retires the pending write, so it also masks busy.
    always_comb begin
      wb_hit  = (BYPASS != 0) && regwren_i && (rd_i == rs_i[p]);
      rd_val  = regs[rs_i[p]];
      rd_busy = busy_vec_o[rs_i[p]];
      if (rs_i[p] == reg_addr_t'(ZERO_IDX)) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end else if (wb_hit) begin
        rd_val  = datawb_i;
        rd_busy = 1'b0;
      end
    end

    if (SYNC_READ != 0) begin : g_sync
      reg_data_t q_data;
      logic      q_busy;
      always_ff @(posedge clk) begin
        if (rst) begin
          q_data <= '0;
          q_busy <= 1'b0;
        end else begin
          q_data <= rd_val;
          q_busy <= rd_busy;
        end
      end
      assign rsdata_o[p] = q_data;
      assign rsbusy_o[p] = q_busy;
    end else begin : g_comb
      assign rsdata_o[p] = rd_val;
      assign rsbusy_o[p] = rd_busy;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam logic [31:0] SP = 32'h0100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Shared stimulus for the 32-register, 2-port instances (A: bypass/comb, B: no bypass/sync)
  logic [1:0][4:0]  rs;
  logic [4:0]       rd, mrd;
  logic [31:0]      wd;
  logic             wren, mark;
  logic [1:0][31:0] rdat_a, rdat_b;
  logic [1:0]       rbusy_a, rbusy_b;
  logic [31:0]      bvec_a, bvec_b;

  // 16-register, 3-port instance (C)
  logic [2:0][3:0]  rs_c;
  logic [3:0]       rd_c, mrd_c;
  logic [31:0]      wd_c;
  logic             wren_c, mark_c;
  logic [2:0][31:0] rdat_c;
  logic [2:0]       rbusy_c;
  logic [15:0]      bvec_c;

  register_file_mp #(.DWIDTH(32), .NUM_REGS(32), .NRD(2), .BYPASS(1), .SYNC_READ(0), .SP_INIT(SP)) dut_a (
    .clk(clk), .rst(rst), .rs_i(rs), .rsdata_o(rdat_a), .rsbusy_o(rbusy_a), .rd_i(rd),
    .datawb_i(wd), .regwren_i(wren), .mark_i(mark), .mark_rd_i(mrd), .busy_vec_o(bvec_a));

  register_file_mp #(.DWIDTH(32), .NUM_REGS(32), .NRD(2), .BYPASS(0), .SYNC_READ(1), .SP_INIT(SP)) dut_b (
    .clk(clk), .rst(rst), .rs_i(rs), .rsdata_o(rdat_b), .rsbusy_o(rbusy_b), .rd_i(rd),
    .datawb_i(wd), .regwren_i(wren), .mark_i(mark), .mark_rd_i(mrd), .busy_vec_o(bvec_b));

  register_file_mp #(.DWIDTH(32), .NUM_REGS(16), .NRD(3), .BYPASS(1), .SYNC_READ(0), .SP_INIT(SP)) dut_c (
    .clk(clk), .rst(rst), .rs_i(rs_c), .rsdata_o(rdat_c), .rsbusy_o(rbusy_c), .rd_i(rd_c),
    .datawb_i(wd_c), .regwren_i(wren_c), .mark_i(mark_c), .mark_rd_i(mrd_c), .busy_vec_o(bvec_c));

  int checks = 0;
  int passed = 0;

  // Reference model: architectural contents and pending-write flags
  logic [31:0] mem  [32];
  bit          bz   [32];
  logic [31:0] memc [16];
  bit          bzc  [16];
  logic [31:0] expb_d [2];
  logic        expb_b [2];

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wren && rd == a) return wd;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return (a != 0) && bz[a] && !(wren && rd == a);
  endfunction

  function automatic logic [31:0] exp_rd_c(input logic [3:0] a);
    if (a == 0) return 32'h0;
    if (wren_c && rd_c == a) return wd_c;
    return memc[a];
  endfunction

  function automatic logic exp_busy_c(input logic [3:0] a);
    return (a != 0) && bzc[a] && !(wren_c && rd_c == a);
  endfunction

  function automatic logic [31:0] vec_a();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = bz[i];
    return v;
  endfunction

  function automatic logic [15:0] vec_c();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = bzc[i];
    return v;
  endfunction

  task automatic idle();
    wren = 0; mark = 0; rd = '0; mrd = '0; wd = '0;
    wren_c = 0; mark_c = 0; rd_c = '0; mrd_c = '0; wd_c = '0;
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      expb_d[p] = (rst || rs[p] == 0) ? 32'h0 : mem[rs[p]];
      expb_b[p] = !rst && rs[p] != 0 && bz[rs[p]];
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mem[i] = (i == 2) ? SP : 32'h0; bz[i] = 0; end
      for (int i = 0; i < 16; i++) begin memc[i] = (i == 2) ? SP : 32'h0; bzc[i] = 0; end
    end else begin
      if (wren && rd != 0) begin mem[rd] = wd; bz[rd] = 0; end
      if (mark && mrd != 0) bz[mrd] = 1;
      if (wren_c && rd_c != 0) begin memc[rd_c] = wd_c; bzc[rd_c] = 0; end
      if (mark_c && mrd_c != 0) bzc[mrd_c] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rs = '0; rs_c = '0;
    tick(); tick();
    rst = 0;
    #1;
    checks++; if (rdat_b !== 64'h0) $display("FAIL reset_sync_out: got %h want 0", rdat_b); else passed++;
    for (int r = 0; r < 32; r++) begin
      rs[0] = 5'(r); rs[1] = 5'(31 - r);
      #1;
      checks++;
      if (rdat_a[0] !== ((r == 2) ? SP : 32'h0))
        $display("FAIL reset_read x%0d: got %h want %h", r, rdat_a[0], (r == 2) ? SP : 32'h0);
      else passed++;
      checks++; if (rbusy_a[0] !== 1'b0) $display("FAIL reset_busy x%0d: got %b want 0", r, rbusy_a[0]); else passed++;
    end
    checks++; if (bvec_a !== 32'h0) $display("FAIL reset_bvec_a: got %h want 0", bvec_a); else passed++;
    checks++; if (bvec_b !== 32'h0) $display("FAIL reset_bvec_b: got %h want 0", bvec_b); else passed++;
    checks++; if (bvec_c !== 16'h0) $display("FAIL reset_bvec_c: got %h want 0", bvec_c); else passed++;
    rs_c[0] = 4'd2; #1;
    checks++; if (rdat_c[0] !== SP) $display("FAIL reset_sp_c: got %h want %h", rdat_c[0], SP); else passed++;
  endtask

  task automatic test_write_read();
    rs = '0;
    wren = 1; rd = 5'd5; wd = 32'hDEADBEEF;
    tick();
    idle(); rs[0] = 5'd5; #1;
    checks++; if (rdat_a[0] !== 32'hDEADBEEF) $display("FAIL wr_rd_comb: got %h want DEADBEEF", rdat_a[0]); else passed++;
    checks++; if (rdat_b[0] !== 32'h0) $display("FAIL sync_latency: got %h want 0", rdat_b[0]); else passed++;
    tick();
    checks++; if (rdat_b[0] !== 32'hDEADBEEF) $display("FAIL wr_rd_sync: got %h want DEADBEEF", rdat_b[0]); else passed++;
    wren = 1; rd = 5'd0; wd = 32'h1234; rs[0] = 5'd0; #1;
    checks++; if (rdat_a[0] !== 32'h0) $display("FAIL x0_bypass: got %h want 0", rdat_a[0]); else passed++;
    tick();
    idle(); #1;
    checks++; if (rdat_a[0] !== 32'h0) $display("FAIL x0_read: got %h want 0", rdat_a[0]); else passed++;
    checks++; if (rdat_b[0] !== 32'h0) $display("FAIL x0_read_sync: got %h want 0", rdat_b[0]); else passed++;
  endtask

  task automatic test_bypass();
    wren = 1; rd = 5'd7; wd = 32'h1111_1111;
    tick();
    idle(); mark = 1; mrd = 5'd7;
    tick();
    idle(); wren = 1; rd = 5'd7; wd = 32'hA5A5A5A5; rs[1] = 5'd7; #1;
    checks++; if (rdat_a[1] !== 32'hA5A5A5A5) $display("FAIL bypass_data: got %h want A5A5A5A5", rdat_a[1]); else passed++;
    checks++; if (rbusy_a[1] !== 1'b0) $display("FAIL bypass_busy: got %b want 0", rbusy_a[1]); else passed++;
    checks++; if (bvec_a[7] !== 1'b1) $display("FAIL bypass_pending: got %b want 1", bvec_a[7]); else passed++;
    tick();
    checks++; if (rdat_b[1] !== 32'h1111_1111) $display("FAIL nobypass_data: got %h want 11111111", rdat_b[1]); else passed++;
    checks++; if (rbusy_b[1] !== 1'b1) $display("FAIL nobypass_busy: got %b want 1", rbusy_b[1]); else passed++;
    idle(); #1;
    checks++; if (rdat_a[1] !== 32'hA5A5A5A5) $display("FAIL bypass_stored: got %h want A5A5A5A5", rdat_a[1]); else passed++;
    checks++; if (bvec_a[7] !== 1'b0) $display("FAIL bypass_cleared: got %b want 0", bvec_a[7]); else passed++;
  endtask

  task automatic test_scoreboard();
    rs[0] = 5'd3; mark = 1; mrd = 5'd3; #1;
    checks++; if (rbusy_a[0] !== 1'b0) $display("FAIL mark_early: got %b want 0", rbusy_a[0]); else passed++;
    tick();
    idle(); #1;
    checks++; if (rbusy_a[0] !== 1'b1) $display("FAIL mark_busy: got %b want 1", rbusy_a[0]); else passed++;
    wren = 1; rd = 5'd3; wd = 32'd9;
    tick();
    idle(); #1;
    checks++; if (rbusy_a[0] !== 1'b0) $display("FAIL wb_clear: got %b want 0", rbusy_a[0]); else passed++;
    checks++; if (rdat_a[0] !== 32'd9) $display("FAIL wb_data: got %h want 9", rdat_a[0]); else passed++;
    mark = 1; mrd = 5'd3; wren = 1; rd = 5'd3; wd = 32'd10;
    tick();
    idle(); #1;
    checks++; if (rbusy_a[0] !== 1'b1) $display("FAIL mark_wins: got %b want 1", rbusy_a[0]); else passed++;
    checks++; if (rdat_a[0] !== 32'd10) $display("FAIL mark_wins_data: got %h want a", rdat_a[0]); else passed++;
    mark = 1; mrd = 5'd0;
    tick();
    idle(); #1;
    checks++; if (bvec_a !== 32'h8) $display("FAIL mark_x0: got %h want 00000008", bvec_a); else passed++;
    wren = 1; rd = 5'd3; wd = 32'd11;
    tick();
    idle();
  endtask

  task automatic test_reset_midstream();
    mark = 1; mrd = 5'd4;
    tick();
    idle(); #1;
    checks++; if (bvec_b[4] !== 1'b1) $display("FAIL mid_busy_set: got %b want 1", bvec_b[4]); else passed++;
    rst = 1; wren = 1; rd = 5'd6; wd = 32'd77; mark = 1; mrd = 5'd8;
    tick();
    rst = 0; idle(); #1;
    checks++; if (bvec_a !== 32'h0) $display("FAIL mid_rst_bvec_a: got %h want 0", bvec_a); else passed++;
    checks++; if (bvec_b !== 32'h0) $display("FAIL mid_rst_bvec_b: got %h want 0", bvec_b); else passed++;
    checks++; if (rdat_b !== 64'h0) $display("FAIL mid_rst_sync_out: got %h want 0", rdat_b); else passed++;
    rs[0] = 5'd6; rs[1] = 5'd5; #1;
    checks++; if (rdat_a[0] !== 32'h0) $display("FAIL rst_write_dropped: got %h want 0", rdat_a[0]); else passed++;
    checks++; if (rdat_a[1] !== 32'h0) $display("FAIL rst_clears_x5: got %h want 0", rdat_a[1]); else passed++;
  endtask

  task automatic test_sweep();
    for (int r = 1; r < 16; r++) begin
      wren_c = 1; rd_c = 4'(r); wd_c = $urandom;
      tick();
    end
    idle();
    for (int r = 0; r < 16; r++) begin
      rs_c[0] = 4'(r); rs_c[1] = 4'((r + 5) % 16); rs_c[2] = 4'((r + 11) % 16);
      #1;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rdat_c[p] !== exp_rd_c(rs_c[p]))
          $display("FAIL sweep_port%0d x%0d: got %h want %h", p, rs_c[p], rdat_c[p], exp_rd_c(rs_c[p]));
        else passed++;
      end
    end
    rs_c = {4'd9, 4'd9, 4'd9}; #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rdat_c[p] !== memc[9]) $display("FAIL dup_port%0d: got %h want %h", p, rdat_c[p], memc[9]);
      else passed++;
    end
    repeat (200) begin
      wren_c = 1'($urandom_range(0, 1)); rd_c = 4'($urandom); wd_c = $urandom;
      mark_c = ($urandom_range(0, 2) == 0); mrd_c = 4'($urandom);
      for (int p = 0; p < 3; p++) rs_c[p] = ($urandom_range(0, 3) == 0) ? rd_c : 4'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rdat_c[p] !== exp_rd_c(rs_c[p]) || rbusy_c[p] !== exp_busy_c(rs_c[p]))
          $display("FAIL rand_c_port%0d x%0d: got %h/%b want %h/%b", p, rs_c[p], rdat_c[p], rbusy_c[p],
                   exp_rd_c(rs_c[p]), exp_busy_c(rs_c[p]));
        else passed++;
      end
      tick();
      checks++; if (bvec_c !== vec_c()) $display("FAIL rand_c_bvec: got %h want %h", bvec_c, vec_c()); else passed++;
    end
    idle();
  endtask

  task automatic test_random();
    repeat (400) begin
      rst  = ($urandom_range(0, 99) == 0);
      wren = 1'($urandom_range(0, 1)); rd = 5'($urandom); wd = $urandom;
      mark = ($urandom_range(0, 2) == 0); mrd = 5'($urandom);
      rs[0] = 5'($urandom);
      rs[1] = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rdat_a[p] !== exp_rd(rs[p]) || rbusy_a[p] !== exp_busy(rs[p]))
          $display("FAIL rand_a_port%0d x%0d: got %h/%b want %h/%b", p, rs[p], rdat_a[p], rbusy_a[p],
                   exp_rd(rs[p]), exp_busy(rs[p]));
        else passed++;
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rdat_b[p] !== expb_d[p] || rbusy_b[p] !== expb_b[p])
          $display("FAIL rand_b_port%0d: got %h/%b want %h/%b", p, rdat_b[p], rbusy_b[p], expb_d[p], expb_b[p]);
        else passed++;
      end
      checks++; if (bvec_a !== vec_a()) $display("FAIL rand_bvec_a: got %h want %h", bvec_a, vec_a()); else passed++;
      checks++; if (bvec_b !== vec_a()) $display("FAIL rand_bvec_b: got %h want %h", bvec_b, vec_a()); else passed++;
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_midstream();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
